i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- I2S master transmitter. Serialises 24-bit left/right sample pairs onto sdti and generates lrck from bick. It is the send-side counterpart of the AKM4117 i2s_receiver and drives DAC/codec serial inputs.
- A one-deep holding register decouples the sample producer (start/ready handshake) from frame timing.
- Data are MSB first, with the standard I2S one-bit delay after each lrck edge.

Parameters:
- DATA_WIDTH, 24, sample width per channel.
- SLOT_BITS, 32, bick cycles per channel slot. Must be at least DATA_WIDTH+1. The frame is 2*SLOT_BITS cycles.

Ports:
- bick  in  1  serial bit clock. The only clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. 0 means reset.
- start  in  1  load strobe. Accepted only in a cycle where ready=1.
- data_left  in  DATA_WIDTH  left sample, captured on an accepted start.
- data_right  in  DATA_WIDTH  right sample, captured on an accepted start.
- ready  out  1  holding register empty; next start will be accepted.
- lrck  out  1  word clock. 0 = left slot, 1 = right slot.
- sdti  out  1  serial data out.
- underrun  out  1  one-cycle pulse when a frame starts with no sample pair available.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, lrck=0, sdti=0, underrun=0, ready=1.
  - Holding register and shift registers are cleared.
  - Reset mid-frame aborts the frame; buffered data is discarded, never sent.
- Slot counter cnt runs 0..SLOT_BITS-1 and wraps to 0. lrck toggles on the edge where cnt wraps.
  - lrck period is 2*SLOT_BITS bick cycles, 50% duty.
  - The first left slot begins in the cycle after reset deassertion.
- Slot bit position k is the registered cnt value of the current cycle.
  - k=0: sdti=0 (I2S delay bit).
  - k=1..DATA_WIDTH: sdti is the active channel's bit [DATA_WIDTH-k], i.e. MSB first, LSB at k=DATA_WIDTH.
  - k>DATA_WIDTH: sdti=0.
  - sdti and lrck are both registered and change on the same rising edge.
- Handshake:
  - ready = !full, where full is the registered holding-valid flag.
  - start with ready=1 captures data_left/data_right into the holding register and sets full on the next edge.
  - start with ready=0 is ignored. No error flag is raised.
- Frame boundary is the cycle with cnt==SLOT_BITS-1 and lrck==1. On that edge:
  - full=1: holding left/right move into the left/right shift registers; full clears, so ready=1 next cycle.
  - full=0 and start=1: data_left/data_right bypass straight into the shift registers. full stays 0 and there is no underrun.
  - full=0 and start=0: shift registers load zeros; underrun=1 for exactly the next cycle, otherwise 0.
- Latency: the first frame after reset is always all zeros with no underrun flagged. Its words are sent before any load; underrun is first evaluated at the end of that frame. An accepted pair goes out in the left slot following the next boundary.
- The right word is held in its shift register, untouched, until the right slot begins. Loading the holding register during the right slot never corrupts the in-flight frame.
- Implementation target: counter, lrck toggle, holding register plus full flag, two shift registers, output mux. No other FSM is required.

Test Plan (DATA_WIDTH=24, SLOT_BITS=32):
1. Reset low for 5 cycles, then release, no start:
   - lrck=0, sdti=0, ready=1 during reset.
   - lrck toggles every 32 bick (64-cycle period).
   - underrun pulses once per frame from the end of frame 1 onward; sdti stays 0.
2. Start with left=0xA5A5A5, right=0x5A5A5A during frame 1:
   - ready drops the next cycle.
   - Frame 2 left slot: sdti=0 at k=0, bits 1,0,1,0,0,1,0,1,... at k=1..24, 0 at k=25..31.
   - Right slot carries 0x5A5A5A the same way.
   - ready returns to 1 after the boundary; no underrun.
3. Back-to-back loads:
   - Load pair A, then pair B as soon as ready=1.
   - Frames 2 and 3 carry A then B with no underrun.
   - A start issued while ready=0 (a third pair C) is dropped; frame 4 is zero with underrun=1.
4. Bypass: start asserted exactly in the boundary cycle with ready=1:
   - The pair appears in the immediately following frame.
   - ready stays 1 and underrun stays 0.
5. Reset mid-operation:
   - Assert reset at cnt=10 of a right slot with full=1.
   - Outputs return to reset values immediately, before the next bick edge.
   - After release, frame 1 is zero and the buffered pair is never transmitted.
6. LSB/boundary check with left=0x000001, right=0x800000:
   - Left slot: sdti=1 only at k=24.
   - Right slot: sdti=1 only at k=1.
   - sdti=0 at k=0 and k=25..31 in both slots.

Source files
------------

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter, 24-bit MSB-first slots with one-bit delay
// Frame timing from a free-running slot counter; a one-deep holding register feeds the shift registers.
module i2s_transmitter #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32
) (
   input  logic                  bick,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_left,
   input  logic [DATA_WIDTH-1:0] data_right,
   output logic                  ready,
   output logic                  lrck,
   output logic                  sdti,
   output logic                  underrun
);

   localparam int CW = $clog2(SLOT_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_BITS - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  lrck_q, lrck_d;
   logic                  sdti_q, sdti_d;
   logic                  underrun_q, underrun_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
   logic                  boundary;
   logic                  in_data;

   always_ff @(posedge bick or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         lrck_q     <= 1'b0;
         sdti_q     <= 1'b0;
         underrun_q <= 1'b0;
         full_q     <= 1'b0;
         hold_l_q   <= '0;
         hold_r_q   <= '0;
         sh_l_q     <= '0;
         sh_r_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         lrck_q     <= lrck_d;
         sdti_q     <= sdti_d;
         underrun_q <= underrun_d;
         full_q     <= full_d;
         hold_l_q   <= hold_l_d;
         hold_r_q   <= hold_r_d;
         sh_l_q     <= sh_l_d;
         sh_r_q     <= sh_r_d;
      end
   end

   always_comb begin
      boundary   = (cnt_q == CNT_LAST) && lrck_q;
      cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      lrck_d     = (cnt_q == CNT_LAST) ? ~lrck_q : lrck_q;
      full_d     = full_q;
      hold_l_d   = hold_l_q;
      hold_r_d   = hold_r_q;
      sh_l_d     = sh_l_q;
      sh_r_d     = sh_r_q;
      underrun_d = 1'b0;
      sdti_d     = 1'b0;

      if (boundary) begin
         if (full_q) begin
            sh_l_d = hold_l_q;
            sh_r_d = hold_r_q;
            full_d = 1'b0;
         end else if (start) begin
            sh_l_d = data_left;
            sh_r_d = data_right;
         end else begin
            sh_l_d     = '0;
            sh_r_d     = '0;
            underrun_d = 1'b1;
         end
      end else if (start && !full_q) begin
         hold_l_d = data_left;
         hold_r_d = data_right;
         full_d   = 1'b1;
      end

      // sdti is registered, so it is driven from the slot position of the next cycle
      in_data = (cnt_d != '0) && (cnt_d <= DATA_LAST);
      if (in_data) begin
         if (lrck_d) begin
            sdti_d = sh_r_q[DATA_WIDTH-1];
            sh_r_d = {sh_r_q[DATA_WIDTH-2:0], 1'b0};
         end else begin
            sdti_d = sh_l_q[DATA_WIDTH-1];
            sh_l_d = {sh_l_q[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   assign ready    = !full_q;
   assign lrck     = lrck_q;
   assign sdti     = sdti_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - testbench for i2s_transmitter
// Reference model: per-frame word table indexed by cycle count since reset release.
module tb_i2s_transmitter;

   logic        bick;
   logic        reset;
   logic        start;
   logic [23:0] data_left;
   logic [23:0] data_right;
   logic        ready;
   logic        lrck;
   logic        sdti;
   logic        underrun;

   int          total;
   int          bad;
   int          t;
   logic        pend_v;
   logic [23:0] pend_l, pend_r;
   logic        und_cur;
   logic [23:0] fr_l [64];
   logic [23:0] fr_r [64];
   logic [23:0] rl, rr;

   i2s_transmitter #(.DATA_WIDTH(24), .SLOT_BITS(32)) dut (
      .bick       (bick),
      .reset      (reset),
      .start      (start),
      .data_left  (data_left),
      .data_right (data_right),
      .ready      (ready),
      .lrck       (lrck),
      .sdti       (sdti),
      .underrun   (underrun)
   );

   initial bick = 1'b0;
   always #5 bick = ~bick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic model_reset();
      t       = 0;
      pend_v  = 1'b0;
      pend_l  = '0;
      pend_r  = '0;
      und_cur = 1'b0;
      for (int i = 0; i < 64; i++) begin
         fr_l[i] = '0;
         fr_r[i] = '0;
      end
   endtask

   function automatic logic exp_sdti(input int tt);
      int          k;
      int          f;
      logic [23:0] w;
      k = tt % 32;
      f = (tt / 64) % 64;
      w = (((tt / 32) % 2) == 1) ? fr_r[f] : fr_l[f];
      if (k >= 1 && k <= 24) return w[24 - k];
      return 1'b0;
   endfunction

   // One bick cycle: check outputs mid-cycle, drive inputs, advance model, clock.
   task automatic cyc(input logic s, input logic [23:0] l, input logic [23:0] r);
      int f1;
      @(negedge bick);
      chk("lrck", 32'(lrck), 32'(((t / 32) % 2) == 1));
      chk("sdti", 32'(sdti), 32'(exp_sdti(t)));
      chk("ready", 32'(ready), 32'(!pend_v));
      chk("underrun", 32'(underrun), 32'(und_cur));
      start      = s;
      data_left  = l;
      data_right = r;
      und_cur    = 1'b0;
      if ((t % 64) == 63) begin
         f1 = (t / 64 + 1) % 64;
         if (pend_v) begin
            fr_l[f1] = pend_l;
            fr_r[f1] = pend_r;
            pend_v   = 1'b0;
         end else if (s) begin
            fr_l[f1] = l;
            fr_r[f1] = r;
         end else begin
            fr_l[f1] = '0;
            fr_r[f1] = '0;
            und_cur  = 1'b1;
         end
      end else if (s && !pend_v) begin
         pend_l = l;
         pend_r = r;
         pend_v = 1'b1;
      end
      @(posedge bick);
      #1;
      start = 1'b0;
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 24'h0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_lrck"}, 32'(lrck), 32'd0);
      chk({tag, "_sdti"}, 32'(sdti), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_underrun"}, 32'(underrun), 32'd0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b0;
      start      = 1'b0;
      data_left  = '0;
      data_right = '0;
      model_reset();

      repeat (5) @(posedge bick);
      #1;
      chk_reset_outputs("rst");
      @(posedge bick);
      #1;
      reset = 1'b1;

      // idle frames: zero data, underrun from end of frame 1 onward
      idle(130);

      // fixed pair, then a second pair as soon as ready, then a dropped third pair
      cyc(1'b1, 24'hA5A5A5, 24'h5A5A5A);
      rl = 24'($urandom);
      rr = 24'($urandom);
      while (pend_v) cyc(1'b1, rl, rr);
      cyc(1'b1, rl, rr);
      cyc(1'b1, 24'($urandom), 24'($urandom));
      idle(200);

      // bypass: start exactly on the frame boundary with ready=1
      while (((t % 64) != 63) || pend_v) cyc(1'b0, 24'h0, 24'h0);
      cyc(1'b1, 24'($urandom), 24'($urandom));
      idle(128);

      // LSB / MSB placement
      cyc(1'b1, 24'h000001, 24'h800000);
      idle(150);

      // mid-frame reset with a pair buffered
      while ((t % 64) != 5) cyc(1'b0, 24'h0, 24'h0);
      cyc(1'b1, 24'($urandom), 24'($urandom));
      while ((t % 64) != 42) cyc(1'b0, 24'h0, 24'h0);
      chk("pre_rst_lrck", 32'(lrck), 32'd1);
      chk("pre_rst_ready", 32'(ready), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      repeat (4) @(posedge bick);
      #1;
      reset = 1'b1;
      model_reset();
      idle(140);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
